// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B subtractor, LSB first, one registered borrow stage
//
// Purpose: computes diff = a - b mod 2^WIDTH one bit per clock. Operands are
// captured on an accepted start in IDLE. WIDTH cycles of RUN follow, then one
// DONE cycle in which done is high and diff/borrow/ovf are valid.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   defined   -> ovf is the signed-overflow flag of the last completed result
//   undefined -> ovf is tied to 0 and no operand MSB storage exists
//
// Ports:
//   clk1    in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only in IDLE
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle result-valid pulse (DONE state)
//   diff    out  WIDTH  a - b mod 2^WIDTH, held until the next DONE
//   borrow  out  1      final borrow-out (a < b unsigned)
//   ovf     out  1      signed overflow flag

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  // One-bit serial full subtractor on the operand LSBs.
  logic x, y, d, bout;
  assign x    = a_sh_q[0];
  assign y    = b_sh_q[0];
  assign d    = x ^ y ^ bin_q;
  assign bout = (~x & y) | (~(x ^ y) & bin_q);

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Result fills from the MSB end so bit 0 lands in res[0] after WIDTH shifts.
        res_d  = {d, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        bin_d  = bout;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Publish on the edge entering DONE so outputs are valid while done is high.
          diff_d   = res_d;
          borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (d != a_msb_q);
`endif
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing A − B one bit per clock, LSB first, through a single registered borrow stage. It pairs with the team's ripple full-adder datapath and supplies the inverse arithmetic direction. It trades latency for area in the small arithmetic blocks on the FPGA learning boards. Operands are captured on a start handshake, and the result is presented with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk1  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on an accepted start
- b  input  WIDTH  subtrahend; captured on an accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  A − B mod 2^WIDTH; updated only when done rises
- borrow  output  1  final borrow-out; 1 iff A < B unsigned
- ovf  output  1  signed overflow flag (see Configuration)

## Operation
- FSM states:
  - IDLE → RUN on start=1: latch a and b into shift registers; bit counter = 0; borrow register = 0.
  - RUN: one bit per cycle on the LSBs of the operand shift registers.
    - d = x ^ y ^ bin
    - bout = (~x & y) | (~(x ^ y) & bin)
    - d is shifted into the result register from the MSB end; both operand registers shift right; counter increments.
    - RUN → DONE after the cycle processing bit WIDTH−1 (counter = WIDTH−1).
  - DONE (exactly one cycle): done=1; diff ← result register; borrow ← final bout; ovf updated. DONE → IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued, and operand changes during RUN have no effect.
- diff, borrow and ovf hold their values from the last completed operation until the next DONE.
- Width rules:
  - Counter width is clog2(WIDTH).
  - No arithmetic is wider than 1 bit plus borrow.
  - Borrow-in for bit 0 is always 0.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - State = IDLE.
  - busy=0, done=0, diff=0, borrow=0, ovf=0.
  - Internal shift registers, counter and borrow cleared.
- Latency:
  - start is sampled high at edge k.
  - busy=1 for cycles k+1 .. k+WIDTH.
  - done=1 and a valid diff during cycle k+WIDTH+1.
  - busy=0 in the DONE cycle.
- Back-to-back operation: the earliest next accepted start is the edge ending the DONE cycle + 1, i.e. IDLE must be visited. Throughput is one result per WIDTH+2 cycles.
- Reset mid-RUN aborts the operation. No done pulse is issued. Outputs clear to 0; the previous result is lost.
- start held continuously re-triggers at each IDLE visit.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf computed in DONE as (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the latched operand MSBs.
  - A one-bit MSB store is kept for each operand.
- SERIAL_SUB_OVF_EN undefined: ovf is tied to 0, and no MSB storage is synthesised. The port remains present.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse → done exactly 9 cycles after the start edge; diff=0x1E, borrow=0, ovf=0.
- a=0x10, b=0x20 → diff=0xF0, borrow=1; a=0x00, b=0x00 → diff=0x00, borrow=0; a=0xFF, b=0xFF → diff=0x00, borrow=0.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1; a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1. Without the macro, ovf=0 for both cases.
- start and new operands (a=0x01, b=0x02) driven in RUN cycle 3 and in the DONE cycle of a 0x5A−0x3C run → ignored; result 0x1E; exactly one done pulse; busy stays 0 after return to IDLE.
- rst_n pulsed low in RUN cycle 4 → busy, done, diff and borrow go 0 asynchronously. No done pulse follows. A fresh start of 0x03−0x01 then yields diff=0x02 after 9 cycles.
- Held start with a=0x09, b=0x04 → done pulses every 10 cycles, each with diff=0x05; diff stable between pulses.
